// File: rtl/overlay_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : overlay_frame_sequencer
//  Description : Frame-level controller for the overlay image generator.
//                Validates and buffers corner sets from the corner detector,
//                then commits exactly one set per frame on the generator's
//                end-of-frame flag. Overlay is disabled after STALE_FRAMES
//                consecutive frames without a fresh corner set.
//  Ports       : i_clk, i_rst_n (async, active low)
//                i_corner_valid, i_ul/i_ur/i_dl/i_dr  corner set input
//                                                     {row[19:10], col[9:0]}
//                i_overlay_on                         user overlay switch
//                i_gen_fin / o_gen_recive             end-of-frame handshake
//                o_addr_valid                         1-cycle commit strobe
//                o_ul/o_ur/o_dl/o_dr, o_enable        committed frame state
//                o_stale, o_frame_cnt, o_reject_cnt   status
//  Revision    : 1.0  initial release
// ============================================================================
module overlay_frame_sequencer #(
    parameter int ROWS         = 600,
    parameter int COLS         = 800,
    parameter int STALE_FRAMES = 4,
    parameter int FCNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_corner_valid,
    input  logic [19:0]       i_ul,
    input  logic [19:0]       i_ur,
    input  logic [19:0]       i_dl,
    input  logic [19:0]       i_dr,
    input  logic              i_overlay_on,
    input  logic              i_gen_fin,
    output logic              o_gen_recive,
    output logic              o_addr_valid,
    output logic [19:0]       o_ul,
    output logic [19:0]       o_ur,
    output logic [19:0]       o_dl,
    output logic [19:0]       o_dr,
    output logic              o_enable,
    output logic              o_stale,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic [7:0]        o_reject_cnt
);

    localparam int                c_STALE_W   = $clog2(STALE_FRAMES + 1);
    localparam logic [c_STALE_W-1:0] c_STALE_MAX = c_STALE_W'(STALE_FRAMES);
    // One extra bit so a limit of 1024 does not truncate to zero.
    localparam logic [10:0]       c_ROWS      = 11'(ROWS);
    localparam logic [10:0]       c_COLS      = 11'(COLS);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [19:0]            r_pend_ul, r_pend_ur, r_pend_dl, r_pend_dr;
    logic                   r_pend_flag;
    logic                   r_have_corners;
    logic [c_STALE_W-1:0]   r_stale_cnt;
    logic                   r_gen_recive;
    logic                   r_addr_valid;
    logic [19:0]            r_ul, r_ur, r_dl, r_dr;
    logic                   r_enable;
    logic                   r_stale;
    logic [FCNT_W-1:0]      r_frame_cnt;
    logic [7:0]             r_reject_cnt;

    logic                   w_set_valid;
    logic                   w_have_next;
    logic [c_STALE_W-1:0]   w_stale_next;

    function automatic logic f_in_frame(input logic [19:0] corner);
        return ({1'b0, corner[19:10]} < c_ROWS) && ({1'b0, corner[9:0]} < c_COLS);
    endfunction

    always_comb begin
        w_set_valid = f_in_frame(i_ul) && f_in_frame(i_ur) &&
                      f_in_frame(i_dl) && f_in_frame(i_dr);
    end

    // Values the counters take if a commit happens this cycle.
    always_comb begin
        w_have_next  = r_have_corners | r_pend_flag;
        w_stale_next = r_stale_cnt;
        if (r_pend_flag) begin
            w_stale_next = '0;
        end else if (r_stale_cnt != c_STALE_MAX) begin
            w_stale_next = r_stale_cnt + c_STALE_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_WAIT;
            r_pend_ul      <= '0;
            r_pend_ur      <= '0;
            r_pend_dl      <= '0;
            r_pend_dr      <= '0;
            r_pend_flag    <= 1'b0;
            r_have_corners <= 1'b0;
            r_stale_cnt    <= '0;
            r_gen_recive   <= 1'b0;
            r_addr_valid   <= 1'b0;
            r_ul           <= '0;
            r_ur           <= '0;
            r_dl           <= '0;
            r_dr           <= '0;
            r_enable       <= 1'b0;
            r_stale        <= 1'b0;
            r_frame_cnt    <= '0;
            r_reject_cnt   <= '0;
        end else begin
            r_addr_valid <= 1'b0;

            if (r_state == ST_WAIT) begin
                if (i_gen_fin) begin
                    r_addr_valid   <= 1'b1;
                    r_gen_recive   <= 1'b1;
                    r_frame_cnt    <= r_frame_cnt + FCNT_W'(1);
                    r_have_corners <= w_have_next;
                    r_stale_cnt    <= w_stale_next;
                    r_enable       <= i_overlay_on & w_have_next &
                                      (w_stale_next < c_STALE_MAX);
                    r_stale        <= (w_stale_next == c_STALE_MAX);
                    if (r_pend_flag) begin
                        r_ul        <= r_pend_ul;
                        r_ur        <= r_pend_ur;
                        r_dl        <= r_pend_dl;
                        r_dr        <= r_pend_dr;
                        r_pend_flag <= 1'b0;
                    end
                    r_state <= ST_ACK;
                end
            end else begin
                // fin still high here belongs to the frame already committed.
                if (!i_gen_fin) begin
                    r_gen_recive <= 1'b0;
                    r_state      <= ST_WAIT;
                end
            end

            // Capture sits after the commit so a set arriving on the commit
            // edge re-arms pend_flag for the following frame.
            if (i_corner_valid) begin
                if (w_set_valid) begin
                    r_pend_ul   <= i_ul;
                    r_pend_ur   <= i_ur;
                    r_pend_dl   <= i_dl;
                    r_pend_dr   <= i_dr;
                    r_pend_flag <= 1'b1;
                end else if (r_reject_cnt != 8'hFF) begin
                    r_reject_cnt <= r_reject_cnt + 8'd1;
                end
            end
        end
    end

    assign o_gen_recive = r_gen_recive;
    assign o_addr_valid = r_addr_valid;
    assign o_ul         = r_ul;
    assign o_ur         = r_ur;
    assign o_dl         = r_dl;
    assign o_dr         = r_dr;
    assign o_enable     = r_enable;
    assign o_stale      = r_stale;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_reject_cnt = r_reject_cnt;

endmodule
`default_nettype wire

// File: tb/tb_overlay_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_overlay_frame_sequencer
//  Description : Self-checking bench for overlay_frame_sequencer. Expected
//                commits are queued by the stimulus; a monitor pops and
//                compares on every o_addr_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_overlay_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        corner_valid;
    logic [19:0] ul, ur, dl, dr;
    logic        overlay_on;
    logic        gen_fin;
    logic        gen_recive;
    logic        addr_valid;
    logic [19:0] q_ul, q_ur, q_dl, q_dr;
    logic        enable;
    logic        stale;
    logic [15:0] frame_cnt;
    logic [7:0]  reject_cnt;

    typedef struct packed {
        logic [19:0] ul;
        logic [19:0] ur;
        logic [19:0] dl;
        logic [19:0] dr;
        logic        en;
        logic        st;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_commits = 0;

    overlay_frame_sequencer #(
        .ROWS(600), .COLS(800), .STALE_FRAMES(4), .FCNT_W(16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_corner_valid (corner_valid),
        .i_ul           (ul),
        .i_ur           (ur),
        .i_dl           (dl),
        .i_dr           (dr),
        .i_overlay_on   (overlay_on),
        .i_gen_fin      (gen_fin),
        .o_gen_recive   (gen_recive),
        .o_addr_valid   (addr_valid),
        .o_ul           (q_ul),
        .o_ur           (q_ur),
        .o_dl           (q_dl),
        .o_dr           (q_dr),
        .o_enable       (enable),
        .o_stale        (stale),
        .o_frame_cnt    (frame_cnt),
        .o_reject_cnt   (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every commit strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && addr_valid) begin
            exp_t got;
            exp_t want;
            got = '{ul: q_ul, ur: q_ur, dl: q_dl, dr: q_dr,
                    en: enable, st: stale, fc: frame_cnt};
            n_checks  = n_checks + 1;
            n_commits = n_commits + 1;
            if (exp_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL commit_unexpected: got %h, required no commit", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_errors = n_errors + 1;
                    $display("FAIL commit: got %h, required %h", got, want);
                end
            end
        end
    end

    function automatic logic [19:0] pc(input int r, input int c);
        logic [31:0] rv;
        logic [31:0] cv;
        rv = r;
        cv = c;
        return {rv[9:0], cv[9:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_commit(input logic [19:0] a, input logic [19:0] b,
                                 input logic [19:0] c, input logic [19:0] d,
                                 input logic en, input logic st, input logic [15:0] fc);
        exp_q.push_back('{ul: a, ur: b, dl: c, dr: d, en: en, st: st, fc: fc});
    endtask

    task automatic send_set(input logic [19:0] a, input logic [19:0] b,
                            input logic [19:0] c, input logic [19:0] d);
        ul = a; ur = b; dl = c; dr = d;
        corner_valid = 1'b1;
        tick();
        corner_valid = 1'b0;
    endtask

    // Raise fin for 'hold' cycles; recive must stay high while fin is high
    // and fall one cycle after fin is seen low.
    task automatic fin_frame(input int hold);
        gen_fin = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("recive_high", {31'd0, gen_recive}, 32'd1);
        end
        gen_fin = 1'b0;
        tick();
        chk("recive_low", {31'd0, gen_recive}, 32'd0);
    endtask

    initial begin
        logic [19:0] a_ul, a_ur, a_dl, a_dr;
        logic [19:0] b_ul, b_ur, b_dl, b_dr;
        logic [19:0] c_ul, c_ur, c_dl, c_dr;
        logic [19:0] d_ul, d_ur, d_dl, d_dr;
        logic [19:0] t2_ul, t2_ur, t2_dl, t2_dr;

        rst_n = 1'b0; corner_valid = 1'b0; overlay_on = 1'b0; gen_fin = 1'b0;
        ul = '0; ur = '0; dl = '0; dr = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state, then an empty commit
        chk("reset_addr_valid", {31'd0, addr_valid}, 32'd0);
        chk("reset_recive",     {31'd0, gen_recive}, 32'd0);
        chk("reset_enable",     {31'd0, enable},     32'd0);
        chk("reset_stale",      {31'd0, stale},      32'd0);
        chk("reset_frame_cnt",  {16'd0, frame_cnt},  32'd0);
        chk("reset_reject_cnt", {24'd0, reject_cnt}, 32'd0);
        chk("reset_ul",         {12'd0, q_ul},       32'd0);
        expect_commit('0, '0, '0, '0, 1'b0, 1'b0, 16'd1);
        fin_frame(1);

        // 2: first valid set, fin held a few cycles
        t2_ul = 20'h190C8; t2_ur = 20'h1912C; t2_dl = 20'h320C8; t2_dr = 20'h3212C;
        overlay_on = 1'b1;
        send_set(pc(100, 200), pc(100, 300), pc(200, 200), pc(200, 300));
        expect_commit(t2_ul, t2_ur, t2_dl, t2_dr, 1'b1, 1'b0, 16'd2);
        fin_frame(3);

        // 3: rejects (row 600, col 800) and saturation at 255
        send_set(pc(600, 0), pc(0, 0), pc(0, 0), pc(0, 0));
        chk("reject_row", {24'd0, reject_cnt}, 32'd1);
        send_set(pc(0, 0), pc(0, 800), pc(0, 0), pc(0, 0));
        chk("reject_col", {24'd0, reject_cnt}, 32'd2);
        ul = pc(600, 800);
        corner_valid = 1'b1;
        repeat (253) tick();
        chk("reject_255", {24'd0, reject_cnt}, 32'd255);
        tick();
        corner_valid = 1'b0;
        chk("reject_sat", {24'd0, reject_cnt}, 32'd255);
        expect_commit(t2_ul, t2_ur, t2_dl, t2_dr, 1'b1, 1'b0, 16'd3);
        fin_frame(1);

        // 4: stale timeout, saturation, recovery, overlay switch timing
        a_ul = pc(10, 20); a_ur = pc(10, 700); a_dl = pc(500, 20); a_dr = pc(500, 700);
        send_set(a_ul, a_ur, a_dl, a_dr);
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b1, 1'b0, 16'd4);
        fin_frame(1);
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b1, 1'b0, 16'd5);
        fin_frame(1);
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b1, 1'b0, 16'd6);
        fin_frame(1);
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b1, 1'b0, 16'd7);
        fin_frame(1);
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b0, 1'b1, 16'd8);
        fin_frame(1);
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b0, 1'b1, 16'd9);
        fin_frame(1);
        b_ul = pc(0, 0); b_ur = pc(0, 799); b_dl = pc(599, 0); b_dr = pc(599, 799);
        send_set(b_ul, b_ur, b_dl, b_dr);
        chk("boundary_not_rejected", {24'd0, reject_cnt}, 32'd255);
        expect_commit(b_ul, b_ur, b_dl, b_dr, 1'b1, 1'b0, 16'd10);
        fin_frame(1);
        overlay_on = 1'b0;
        expect_commit(b_ul, b_ur, b_dl, b_dr, 1'b0, 1'b0, 16'd11);
        fin_frame(1);
        overlay_on = 1'b1;
        repeat (3) tick();
        chk("enable_waits_commit", {31'd0, enable}, 32'd0);
        expect_commit(b_ul, b_ur, b_dl, b_dr, 1'b1, 1'b0, 16'd12);
        fin_frame(1);

        // 5: new set arrives on the same edge fin is sampled
        c_ul = pc(1, 2);   c_ur = pc(1, 3);   c_dl = pc(4, 2);   c_dr = pc(4, 3);
        d_ul = pc(50, 60); d_ur = pc(50, 70); d_dl = pc(80, 60); d_dr = pc(80, 70);
        send_set(c_ul, c_ur, c_dl, c_dr);
        expect_commit(c_ul, c_ur, c_dl, c_dr, 1'b1, 1'b0, 16'd13);
        ul = d_ul; ur = d_ur; dl = d_dl; dr = d_dr;
        corner_valid = 1'b1;
        gen_fin = 1'b1;
        tick();
        corner_valid = 1'b0;
        chk("recive_simul", {31'd0, gen_recive}, 32'd1);
        gen_fin = 1'b0;
        tick();
        chk("recive_simul_low", {31'd0, gen_recive}, 32'd0);
        expect_commit(d_ul, d_ur, d_dl, d_dr, 1'b1, 1'b0, 16'd14);
        fin_frame(1);

        // 6: async reset while in ACK discards pending set
        expect_commit(a_ul, a_ur, a_dl, a_dr, 1'b1, 1'b0, 16'd15);
        send_set(a_ul, a_ur, a_dl, a_dr);
        gen_fin = 1'b1;
        tick();
        send_set(b_ul, b_ur, b_dl, b_dr);
        rst_n = 1'b0;
        #1;
        chk("arst_recive",     {31'd0, gen_recive}, 32'd0);
        chk("arst_enable",     {31'd0, enable},     32'd0);
        chk("arst_frame_cnt",  {16'd0, frame_cnt},  32'd0);
        chk("arst_reject_cnt", {24'd0, reject_cnt}, 32'd0);
        chk("arst_ul",         {12'd0, q_ul},       32'd0);
        gen_fin = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_recive", {31'd0, gen_recive}, 32'd0);
        chk("post_rst_cnt",    {16'd0, frame_cnt},  32'd0);
        n_commits = 0;
        expect_commit('0, '0, '0, '0, 1'b0, 1'b0, 16'd1);
        fin_frame(10);
        tick();
        chk("single_commit", n_commits, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
